// File: rtl/sid_sched_pkg.sv
// rtl/sid_sched_pkg.sv - shared command type and timing constant for the SID bus scheduler
package sid_sched_pkg;

  typedef struct packed {
    logic       chip;
    logic       we;
    logic [4:0] addr;
    logic [7:0] data;
  } sid_cmd_t;

  // Cycles between the ce_1m tick and the register strobe it schedules.
  localparam int ISSUE_OFS = 1;

endpackage

// File: rtl/sid_bus_sched_if.sv
// rtl/sid_bus_sched_if.sv - CPU, aux-writer and SID register-port signals of the scheduler
interface sid_bus_sched_if #(
  parameter int DUAL       = 0,
  parameter int FIFO_DEPTH = 8
);
  localparam int N  = (DUAL != 0) ? 2 : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic          ce_1m;
  logic          cpu_req;
  logic          cpu_chip;
  logic          cpu_we;
  logic [4:0]    cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_busy;
  logic [7:0]    cpu_dout;
  logic          cpu_dvalid;
  logic          cpu_ovf;
  logic          aux_valid;
  logic          aux_ready;
  logic          aux_chip;
  logic [4:0]    aux_addr;
  logic [7:0]    aux_data;
  logic [LW-1:0] fifo_level;
  logic [N-1:0]  sid_cs;
  logic          sid_we;
  logic [4:0]    sid_addr;
  logic [7:0]    sid_din;
  logic [7:0]    sid_dout;

  modport slave (
    input  ce_1m, cpu_req, cpu_chip, cpu_we, cpu_addr, cpu_din,
    input  aux_valid, aux_chip, aux_addr, aux_data, sid_dout,
    output cpu_busy, cpu_dout, cpu_dvalid, cpu_ovf, aux_ready, fifo_level,
    output sid_cs, sid_we, sid_addr, sid_din
  );

  modport master (
    output ce_1m, cpu_req, cpu_chip, cpu_we, cpu_addr, cpu_din,
    output aux_valid, aux_chip, aux_addr, aux_data, sid_dout,
    input  cpu_busy, cpu_dout, cpu_dvalid, cpu_ovf, aux_ready, fifo_level,
    input  sid_cs, sid_we, sid_addr, sid_din
  );

endinterface

// File: rtl/sid_cmd_fifo.sv
// rtl/sid_cmd_fifo.sv - synchronous FIFO of SID register commands
module sid_cmd_fifo
  import sid_sched_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  sid_cmd_t      din_i,
  input  logic          pop_i,
  output sid_cmd_t      dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  sid_cmd_t      mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];
  assign level_o = level_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = pop_ok ? rd_q + AW'(1) : rd_q;
    level_d = level_q + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/sid_bus_sched.sv
// rtl/sid_bus_sched.sv - one register access per ce_1m slot, shared between CPU and aux writer
module sid_bus_sched
  import sid_sched_pkg::*;
#(
  parameter int DUAL       = 0,
  parameter int FIFO_DEPTH = 8
) (
  input logic             clk,
  input logic             reset,
  sid_bus_sched_if.slave  bus
);

  localparam int N  = (DUAL != 0) ? 2 : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [ISSUE_OFS-1:0] ce_sr_q;
  sid_cmd_t             cpu_cmd_q, cpu_cmd_d;
  logic                 cpu_busy_q, cpu_busy_d;
  logic                 cpu_pend_q, cpu_pend_d;
  logic                 cpu_ovf_q, cpu_ovf_d;
  logic                 last_cpu_q, last_cpu_d;
  logic [1:0]           rd_pipe_q, rd_pipe_d;
  logic [7:0]           cpu_dout_q, cpu_dout_d;

  sid_cmd_t             aux_cmd, fifo_head, issue_cmd;
  logic                 fifo_full, fifo_empty, fifo_push;
  logic [LW-1:0]        fifo_level;
  logic                 slot, grant_cpu, grant_aux, issue, chip_eff;

  assign aux_cmd   = {bus.aux_chip, 1'b1, bus.aux_addr, bus.aux_data};
  assign fifo_push = bus.aux_valid && !fifo_full;

  sid_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .din_i   (aux_cmd),
    .pop_i   (grant_aux),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Grant uses only registered state, so captures at the end of the tick cycle are eligible.
  assign slot      = ce_sr_q[ISSUE_OFS-1];
  assign grant_cpu = slot && cpu_pend_q && (fifo_empty || !last_cpu_q);
  assign grant_aux = slot && !fifo_empty && !grant_cpu;
  assign issue     = grant_cpu || grant_aux;
  assign issue_cmd = grant_cpu ? cpu_cmd_q : fifo_head;
  assign chip_eff  = (DUAL != 0) ? issue_cmd.chip : 1'b0;

  assign bus.sid_cs     = issue ? (N'(1) << chip_eff) : '0;
  assign bus.sid_we     = issue && issue_cmd.we;
  assign bus.sid_addr   = issue ? issue_cmd.addr : '0;
  assign bus.sid_din    = issue ? issue_cmd.data : '0;
  assign bus.cpu_busy   = cpu_busy_q;
  assign bus.cpu_dout   = cpu_dout_q;
  assign bus.cpu_dvalid = rd_pipe_q[1];
  assign bus.cpu_ovf    = cpu_ovf_q;
  assign bus.aux_ready  = !fifo_full;
  assign bus.fifo_level = fifo_level;

  always_comb begin
    cpu_cmd_d  = cpu_cmd_q;
    cpu_busy_d = cpu_busy_q;
    cpu_pend_d = cpu_pend_q;
    cpu_ovf_d  = cpu_ovf_q;
    last_cpu_d = last_cpu_q;
    cpu_dout_d = cpu_dout_q;
    rd_pipe_d  = {rd_pipe_q[0], grant_cpu && !cpu_cmd_q.we};

    if (bus.cpu_req) begin
      if (cpu_busy_q) begin
        cpu_ovf_d = 1'b1;
      end else begin
        cpu_cmd_d  = {bus.cpu_chip, bus.cpu_we, bus.cpu_addr, bus.cpu_din};
        cpu_busy_d = 1'b1;
        cpu_pend_d = 1'b1;
      end
    end

    // A read stays busy (but no longer pending) until its data returns two cycles later.
    if (grant_cpu) begin
      cpu_pend_d = 1'b0;
      if (cpu_cmd_q.we) cpu_busy_d = 1'b0;
    end

    if (rd_pipe_q[0]) begin
      cpu_dout_d = bus.sid_dout;
      cpu_busy_d = 1'b0;
    end

    if (issue) last_cpu_d = grant_cpu;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_sr_q    <= '0;
      cpu_cmd_q  <= '0;
      cpu_busy_q <= 1'b0;
      cpu_pend_q <= 1'b0;
      cpu_ovf_q  <= 1'b0;
      last_cpu_q <= 1'b0;
      rd_pipe_q  <= '0;
      cpu_dout_q <= '0;
    end else begin
      ce_sr_q    <= ISSUE_OFS'({ce_sr_q, bus.ce_1m});
      cpu_cmd_q  <= cpu_cmd_d;
      cpu_busy_q <= cpu_busy_d;
      cpu_pend_q <= cpu_pend_d;
      cpu_ovf_q  <= cpu_ovf_d;
      last_cpu_q <= last_cpu_d;
      rd_pipe_q  <= rd_pipe_d;
      cpu_dout_q <= cpu_dout_d;
    end
  end

endmodule

// File: tb/tb_sid_bus_sched.sv
// tb/tb_sid_bus_sched.sv - directed checks of the SID bus scheduler (single and dual SID)
module tb_sid_bus_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sid_bus_sched_if #(.DUAL(0), .FIFO_DEPTH(8)) b0 ();
  sid_bus_sched_if #(.DUAL(1), .FIFO_DEPTH(8)) b1 ();

  sid_bus_sched #(.DUAL(0), .FIFO_DEPTH(8)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  sid_bus_sched #(.DUAL(1), .FIFO_DEPTH(8)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));

  function automatic logic [7:0] model_rd(input logic [4:0] a);
    return (a == 5'h1B) ? 8'hA5 : ({3'b000, a} ^ 8'h3C);
  endfunction

  // SID register model: data_out valid the cycle after a read strobe.
  always @(posedge clk) begin
    if (b0.sid_cs != 1'b0 && !b0.sid_we) b0.sid_dout <= model_rd(b0.sid_addr);
    if (b1.sid_cs != 2'b00 && !b1.sid_we) b1.sid_dout <= model_rd(b1.sid_addr);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b0.ce_1m = 0; b0.cpu_req = 0; b0.cpu_chip = 0; b0.cpu_we = 0; b0.cpu_addr = 0; b0.cpu_din = 0;
    b0.aux_valid = 0; b0.aux_chip = 0; b0.aux_addr = 0; b0.aux_data = 0;
    b1.ce_1m = 0; b1.cpu_req = 0; b1.cpu_chip = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_din = 0;
    b1.aux_valid = 0; b1.aux_chip = 0; b1.aux_addr = 0; b1.aux_data = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic slot0();
    b0.ce_1m = 1;
    tick();
    b0.ce_1m = 0;
  endtask

  typedef struct {
    logic       ce;
    logic       av;
    logic [4:0] aaddr;
    logic [7:0] adata;
    logic       ecs;
    logic       ewe;
    logic [4:0] eaddr;
    logic [7:0] edin;
    logic [3:0] elvl;
  } vec_t;

  function automatic vec_t mk(input logic ce, input logic av, input logic [4:0] aa, input logic [7:0] ad,
                              input logic cs, input logic [4:0] ea, input logic [7:0] ed, input logic [3:0] lv);
    vec_t v;
    v.ce = ce; v.av = av; v.aaddr = aa; v.adata = ad;
    v.ecs = cs; v.ewe = cs; v.eaddr = ea; v.edin = ed; v.elvl = lv;
    return v;
  endfunction

  vec_t tv[17];
  int   aux_idx;
  logic exp_cpu;

  initial begin
    tv[0]  = mk(0, 1, 5'h00, 8'h11, 0, 5'h00, 8'h00, 0);
    tv[1]  = mk(0, 1, 5'h01, 8'h22, 0, 5'h00, 8'h00, 1);
    tv[2]  = mk(0, 1, 5'h18, 8'h0F, 0, 5'h00, 8'h00, 2);
    tv[3]  = mk(1, 0, 5'h00, 8'h00, 0, 5'h00, 8'h00, 3);
    tv[4]  = mk(0, 0, 5'h00, 8'h00, 1, 5'h00, 8'h11, 3);
    tv[5]  = mk(0, 0, 5'h00, 8'h00, 0, 5'h00, 8'h00, 2);
    tv[6]  = mk(0, 0, 5'h00, 8'h00, 0, 5'h00, 8'h00, 2);
    tv[7]  = mk(1, 0, 5'h00, 8'h00, 0, 5'h00, 8'h00, 2);
    tv[8]  = mk(0, 0, 5'h00, 8'h00, 1, 5'h01, 8'h22, 2);
    tv[9]  = mk(0, 0, 5'h00, 8'h00, 0, 5'h00, 8'h00, 1);
    tv[10] = mk(0, 0, 5'h00, 8'h00, 0, 5'h00, 8'h00, 1);
    tv[11] = mk(1, 0, 5'h00, 8'h00, 0, 5'h00, 8'h00, 1);
    tv[12] = mk(0, 0, 5'h00, 8'h00, 1, 5'h18, 8'h0F, 1);
    tv[13] = mk(0, 0, 5'h00, 8'h00, 0, 5'h00, 8'h00, 0);
    tv[14] = mk(0, 0, 5'h00, 8'h00, 0, 5'h00, 8'h00, 0);
    tv[15] = mk(1, 0, 5'h00, 8'h00, 0, 5'h00, 8'h00, 0);
    tv[16] = mk(0, 0, 5'h00, 8'h00, 0, 5'h00, 8'h00, 0);

    idle_inputs();
    do_reset();

    check("rst_cs", 32'(b0.sid_cs), 0);
    check("rst_we", 32'(b0.sid_we), 0);
    check("rst_addr_din", 32'({b0.sid_addr, b0.sid_din}), 0);
    check("rst_busy", 32'(b0.cpu_busy), 0);
    check("rst_dout", 32'(b0.cpu_dout), 0);
    check("rst_dvalid", 32'(b0.cpu_dvalid), 0);
    check("rst_ovf", 32'(b0.cpu_ovf), 0);
    check("rst_level", 32'(b0.fifo_level), 0);
    check("rst_ready", 32'(b0.aux_ready), 1);

    // Aux-only writes: one strobe per slot, in push order.
    for (int i = 0; i < 17; i++) begin
      b0.ce_1m = tv[i].ce; b0.aux_valid = tv[i].av; b0.aux_addr = tv[i].aaddr; b0.aux_data = tv[i].adata;
      #0;
      check($sformatf("t1_cs[%0d]", i), 32'(b0.sid_cs), 32'(tv[i].ecs));
      check($sformatf("t1_we[%0d]", i), 32'(b0.sid_we), 32'(tv[i].ewe));
      check($sformatf("t1_addr[%0d]", i), 32'(b0.sid_addr), 32'(tv[i].eaddr));
      check($sformatf("t1_din[%0d]", i), 32'(b0.sid_din), 32'(tv[i].edin));
      check($sformatf("t1_lvl[%0d]", i), 32'(b0.fifo_level), 32'(tv[i].elvl));
      check($sformatf("t1_rdy[%0d]", i), 32'(b0.aux_ready), 1);
      tick();
    end
    idle_inputs();

    // Contention: CPU and aux alternate.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      b0.aux_valid = 1; b0.aux_addr = 5'(16 + i); b0.aux_data = 8'('h80 + i);
      tick();
    end
    b0.aux_valid = 0;
    check("t2_level4", 32'(b0.fifo_level), 4);
    aux_idx = 0;
    for (int s = 0; s < 8; s++) begin
      if (b0.cpu_busy == 1'b0) begin
        b0.cpu_req = 1; b0.cpu_we = 1; b0.cpu_addr = 5'h04; b0.cpu_din = 8'h41;
      end
      tick();
      b0.cpu_req = 0;
      tick();
      slot0();
      exp_cpu = (s % 2 == 0);
      check($sformatf("t2_cs[%0d]", s), 32'(b0.sid_cs), 1);
      check($sformatf("t2_we[%0d]", s), 32'(b0.sid_we), 1);
      if (exp_cpu) begin
        check($sformatf("t2_cpu_addr[%0d]", s), 32'(b0.sid_addr), 'h04);
        check($sformatf("t2_cpu_din[%0d]", s), 32'(b0.sid_din), 'h41);
      end else begin
        check($sformatf("t2_aux_addr[%0d]", s), 32'(b0.sid_addr), 32'(16 + aux_idx));
        check($sformatf("t2_aux_din[%0d]", s), 32'(b0.sid_din), 32'('h80 + aux_idx));
        aux_idx++;
      end
      tick();
      check($sformatf("t2_busy[%0d]", s), 32'(b0.cpu_busy), exp_cpu ? 0 : 1);
      tick();
    end
    check("t2_level0", 32'(b0.fifo_level), 0);
    check("t2_ovf", 32'(b0.cpu_ovf), 0);

    // CPU read: strobe at T+1, dvalid at T+3.
    do_reset();
    b0.cpu_req = 1; b0.cpu_we = 0; b0.cpu_addr = 5'h1B;
    tick();
    b0.cpu_req = 0;
    b0.ce_1m = 1;
    check("t3_busy_T", 32'(b0.cpu_busy), 1);
    check("t3_cs_T", 32'(b0.sid_cs), 0);
    tick();
    b0.ce_1m = 0;
    check("t3_cs_T1", 32'(b0.sid_cs), 1);
    check("t3_we_T1", 32'(b0.sid_we), 0);
    check("t3_addr_T1", 32'(b0.sid_addr), 'h1B);
    tick();
    check("t3_cs_T2", 32'(b0.sid_cs), 0);
    check("t3_dvalid_T2", 32'(b0.cpu_dvalid), 0);
    check("t3_busy_T2", 32'(b0.cpu_busy), 1);
    tick();
    check("t3_dvalid_T3", 32'(b0.cpu_dvalid), 1);
    check("t3_dout_T3", 32'(b0.cpu_dout), 'hA5);
    check("t3_busy_T3", 32'(b0.cpu_busy), 0);
    tick();
    check("t3_dvalid_T4", 32'(b0.cpu_dvalid), 0);
    check("t3_dout_T4", 32'(b0.cpu_dout), 'hA5);

    // Fill past full, CPU overflow, then drain.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      b0.aux_valid = 1; b0.aux_addr = 5'(k); b0.aux_data = 8'('h50 + k);
      #0;
      check($sformatf("t4_lvl[%0d]", k), 32'(b0.fifo_level), 32'(k));
      check($sformatf("t4_rdy[%0d]", k), 32'(b0.aux_ready), (k < 8) ? 1 : 0);
      tick();
    end
    b0.aux_valid = 0;
    check("t4_lvl_full", 32'(b0.fifo_level), 8);
    check("t4_rdy_full", 32'(b0.aux_ready), 0);
    b0.cpu_req = 1; b0.cpu_we = 1; b0.cpu_addr = 5'h07; b0.cpu_din = 8'h99;
    tick();
    b0.cpu_addr = 5'h1F; b0.cpu_din = 8'h00;
    check("t4_busy", 32'(b0.cpu_busy), 1);
    check("t4_ovf_pre", 32'(b0.cpu_ovf), 0);
    tick();
    b0.cpu_req = 0;
    check("t4_ovf", 32'(b0.cpu_ovf), 1);
    tick();
    for (int s = 0; s < 10; s++) begin
      slot0();
      if (s == 0) begin
        check("t4_cpu_cs", 32'(b0.sid_cs), 1);
        check("t4_cpu_ad", 32'({b0.sid_addr, b0.sid_din}), 32'({5'h07, 8'h99}));
      end else if (s <= 8) begin
        check($sformatf("t4_aux_cs[%0d]", s), 32'(b0.sid_cs), 1);
        check($sformatf("t4_aux_ad[%0d]", s), 32'({b0.sid_addr, b0.sid_din}),
              32'({5'(s - 1), 8'('h50 + s - 1)}));
      end else begin
        check("t4_ninth_dropped", 32'(b0.sid_cs), 0);
      end
      tick(); tick(); tick();
    end
    check("t4_lvl_end", 32'(b0.fifo_level), 0);
    check("t4_ovf_sticky", 32'(b0.cpu_ovf), 1);

    // Chip select mapping.
    do_reset();
    b1.cpu_req = 1; b1.cpu_we = 1; b1.cpu_chip = 1; b1.cpu_addr = 5'h18; b1.cpu_din = 8'h0F;
    b0.aux_valid = 1; b0.aux_chip = 1; b0.aux_addr = 5'h05; b0.aux_data = 8'h66;
    tick();
    b1.cpu_req = 0; b0.aux_valid = 0;
    b1.ce_1m = 1; b0.ce_1m = 1;
    tick();
    b1.ce_1m = 0; b0.ce_1m = 0;
    check("t5_dual_cs", 32'(b1.sid_cs), 'b10);
    check("t5_dual_addr", 32'(b1.sid_addr), 'h18);
    check("t5_dual_din", 32'(b1.sid_din), 'h0F);
    check("t5_single_cs", 32'(b0.sid_cs), 1);
    check("t5_single_addr", 32'(b0.sid_addr), 'h05);
    b1.aux_valid = 1; b1.aux_chip = 0; b1.aux_addr = 5'h02; b1.aux_data = 8'h33;
    tick();
    b1.aux_valid = 0;
    tick(); tick();
    b1.ce_1m = 1;
    tick();
    b1.ce_1m = 0;
    check("t5_dual_cs0", 32'(b1.sid_cs), 'b01);
    check("t5_dual_addr0", 32'(b1.sid_addr), 'h02);

    // Reset between read strobe and dvalid.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      b0.aux_valid = 1; b0.aux_addr = 5'(i); b0.aux_data = 8'(i);
      tick();
    end
    b0.aux_valid = 0;
    b0.cpu_req = 1; b0.cpu_we = 0; b0.cpu_addr = 5'h1B;
    tick();
    b0.cpu_req = 0;
    slot0();
    check("t6_cs_T1", 32'(b0.sid_cs), 1);
    check("t6_we_T1", 32'(b0.sid_we), 0);
    tick();
    reset = 1;
    tick();
    reset = 0;
    check("t6_dvalid", 32'(b0.cpu_dvalid), 0);
    check("t6_busy", 32'(b0.cpu_busy), 0);
    check("t6_dout", 32'(b0.cpu_dout), 0);
    check("t6_cs", 32'(b0.sid_cs), 0);
    check("t6_bus", 32'({b0.sid_we, b0.sid_addr, b0.sid_din}), 0);
    check("t6_level", 32'(b0.fifo_level), 0);
    check("t6_ready", 32'(b0.aux_ready), 1);
    check("t6_ovf", 32'(b0.cpu_ovf), 0);
    tick();
    check("t6_dvalid_late", 32'(b0.cpu_dvalid), 0);
    tick(); tick();
    slot0();
    check("t6_no_issue", 32'(b0.sid_cs), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
